// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the writeback stage, MEM/WB register and
// forwarding unit.
package wb_regfile_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned CNT_W     = 32;

  // Index of the hard-wired zero register.
  localparam int unsigned ZERO_REG  = 0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_select.sv
// Writeback value mux: load data versus ALU result, independent of whether
// the write actually commits.
module wb_select
  import wb_regfile_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         memtoreg_in,
  input  logic [W-1:0] read_data_in,
  input  logic [W-1:0] result_alu_in,
  output logic [W-1:0] wb_data
);

  assign wb_data = memtoreg_in ? read_data_in : result_alu_in;

endmodule : wb_select

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file: commits MEM/WB results, serves
// two read ports with write-through bypass, counts committed writes.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W_P = CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memtoreg_in,
  input  logic                 regwrite_in,
  input  logic [ADDR_W-1:0]    rd_in,
  input  logic [DATA_W-1:0]    read_data_in,
  input  logic [DATA_W-1:0]    result_alu_in,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  output logic [DATA_W-1:0]    readdata1,
  output logic [DATA_W-1:0]    readdata2,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_en,
  output logic [CNT_W_P-1:0]   write_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [REG_COUNT];

  wb_select #(.W(DATA_W)) u_wb_select (
    .memtoreg_in   (memtoreg_in),
    .read_data_in  (read_data_in),
    .result_alu_in (result_alu_in),
    .wb_data       (wb_data)
  );

  // Gating by reset also suppresses the bypass while reset is held low.
  assign wb_en = reset && regwrite_in && (rd_in != ZERO_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (wb_en) begin
      regs[rd_in] <= wb_data;
      write_count <= write_count + CNT_W_P'(1);
    end
  end

  // x0 reads zero regardless of array contents; a pending write wins over
  // the stored value so ID sees it in the same cycle.
  always_comb begin
    readdata1 = regs[rs1];
    if (rs1 == ZERO_IDX) begin
      readdata1 = '0;
    end else if (wb_en && (rs1 == rd_in)) begin
      readdata1 = wb_data;
    end
  end

  always_comb begin
    readdata2 = regs[rs2];
    if (rs2 == ZERO_IDX) begin
      readdata2 = '0;
    end else if (wb_en && (rs2 == rd_in)) begin
      readdata2 = wb_data;
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a reduced 4-bit write counter so the
// wrap can be reached in a handful of writes.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk;
  logic                reset;
  logic                memtoreg_in;
  logic                regwrite_in;
  logic [ADDR_W-1:0]   rd_in;
  logic [DATA_W-1:0]   read_data_in;
  logic [DATA_W-1:0]   result_alu_in;
  logic [ADDR_W-1:0]   rs1;
  logic [ADDR_W-1:0]   rs2;
  logic [DATA_W-1:0]   readdata1;
  logic [DATA_W-1:0]   readdata2;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_en;
  logic [TB_CNT_W-1:0] write_count;

  int vectors;
  int miscompares;

  wb_regfile #(.CNT_W_P(TB_CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .memtoreg_in   (memtoreg_in),
    .regwrite_in   (regwrite_in),
    .rd_in         (rd_in),
    .read_data_in  (read_data_in),
    .result_alu_in (result_alu_in),
    .rs1           (rs1),
    .rs2           (rs2),
    .readdata1     (readdata1),
    .readdata2     (readdata2),
    .wb_data       (wb_data),
    .wb_en         (wb_en),
    .write_count   (write_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                       input logic [DATA_W-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // advance past the next rising edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] rd, input logic mem,
                             input logic [DATA_W-1:0] ld, input logic [DATA_W-1:0] alu);
    regwrite_in   = 1'b1;
    rd_in         = rd;
    memtoreg_in   = mem;
    read_data_in  = ld;
    result_alu_in = alu;
  endtask

  task automatic idle();
    regwrite_in = 1'b0;
    rd_in       = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    idle();
    memtoreg_in   = 1'b1;
    read_data_in  = 64'h11;
    result_alu_in = 64'h22;
    rs1 = 5'd4;
    rs2 = 5'd0;

    // reset state, with a write request that must not bypass
    #2;
    regwrite_in = 1'b1;
    rd_in       = 5'd4;
    #1;
    check("rst_rd1_no_bypass", readdata1, 64'h0);
    check("rst_rd2", readdata2, 64'h0);
    check("rst_wb_en", {63'b0, wb_en}, 64'h0);
    check("rst_count", {60'b0, write_count}, 64'h0);
    check("rst_wb_data_follows", wb_data, 64'h11);
    tick();
    check("rst_held_count", {60'b0, write_count}, 64'h0);
    idle();
    reset = 1'b1;

    // load write into x7
    drive_write(5'd7, 1'b1, 64'hDEAD_BEEF, 64'h55);
    rs2 = 5'd0;
    #1;
    check("x7_wb_data", wb_data, 64'hDEAD_BEEF);
    check("x7_wb_en", {63'b0, wb_en}, 64'h1);
    tick();
    idle();
    rs2 = 5'd7;
    #1;
    check("x7_read_rs2", readdata2, 64'hDEAD_BEEF);
    check("x7_count", {60'b0, write_count}, 64'h1);

    // same-cycle bypass on both ports
    drive_write(5'd3, 1'b0, 64'h1, 64'hAA);
    rs1 = 5'd3;
    rs2 = 5'd3;
    #1;
    check("byp_rd1", readdata1, 64'hAA);
    check("byp_rd2", readdata2, 64'hAA);
    tick();
    idle();
    rs2 = 5'd7;
    #1;
    check("x3_stored", readdata1, 64'hAA);
    check("x7_kept", readdata2, 64'hDEAD_BEEF);
    check("x3_count", {60'b0, write_count}, 64'h2);

    // write to x0 is ignored and not counted
    drive_write(5'd0, 1'b0, 64'h0, 64'hFFFF);
    rs1 = 5'd0;
    #1;
    check("x0_wb_en", {63'b0, wb_en}, 64'h0);
    check("x0_rd1", readdata1, 64'h0);
    tick();
    idle();
    #1;
    check("x0_after_rd1", readdata1, 64'h0);
    check("x0_count", {60'b0, write_count}, 64'h2);

    // x9 = 0x77, then a bubble naming x9 must not bypass or write
    drive_write(5'd9, 1'b0, 64'h0, 64'h77);
    tick();
    regwrite_in   = 1'b0;
    rd_in         = 5'd9;
    result_alu_in = 64'h99;
    rs1 = 5'd9;
    #1;
    check("bubble_no_bypass", readdata1, 64'h77);
    tick();
    check("bubble_regs_kept", readdata1, 64'h77);
    check("bubble_count", {60'b0, write_count}, 64'h3);
    idle();

    // x5 = 0x1234 (count 4), then 11 more writes up to 15, one more wraps
    drive_write(5'd5, 1'b0, 64'h0, 64'h1234);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive_write(ADDR_W'(10 + i), 1'b1, 64'h100 + 64'(i), 64'h0);
      tick();
    end
    idle();
    rs1 = 5'd20;
    rs2 = 5'd5;
    #1;
    check("cnt_max", {60'b0, write_count}, 64'hF);
    check("x20_stored", readdata1, 64'h10A);
    check("x5_stored", readdata2, 64'h1234);
    drive_write(5'd21, 1'b0, 64'h0, 64'h5A5A);
    tick();
    idle();
    rs1 = 5'd21;
    #1;
    check("cnt_wrap", {60'b0, write_count}, 64'h0);
    check("x21_stored", readdata1, 64'h5A5A);

    // asynchronous reset mid-cycle clears regs and counter at once
    rs1 = 5'd5;
    #1;
    check("pre_rst_x5", readdata1, 64'h1234);
    drive_write(5'd6, 1'b0, 64'h0, 64'h66);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_x5", readdata1, 64'h0);
    check("async_rst_count", {60'b0, write_count}, 64'h0);
    tick();
    idle();
    reset = 1'b1;
    rs2 = 5'd6;
    #1;
    check("dropped_write_x6", readdata2, 64'h0);
    check("dropped_write_count", {60'b0, write_count}, 64'h0);

    // first edge after release commits
    drive_write(5'd8, 1'b0, 64'h0, 64'h42);
    tick();
    idle();
    rs1 = 5'd8;
    #1;
    check("post_rst_x8", readdata1, 64'h42);
    check("post_rst_count", {60'b0, write_count}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_wb_regfile
